// File: rtl/as_gpio_capture_pkg.sv
// Shared constants and status-FSM type for the GPIO capture block.
package as_pack;

  localparam int nr_gpios            = 32;
  localparam int gpio_addr_width     = 8;
  localparam int DEFAULT_RESULT_ADDR = 4;
  localparam int DEFAULT_PASS_VALUE  = 42;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } as_state_t;

endpackage

// File: rtl/as_gpio_capture_if.sv
// GPIO write strobe plus capture-FIFO read handshake; master drives writes and consumer ready.
interface as_gpio_capture_if;
  import as_pack::*;

  logic                       cs_i;
  logic [gpio_addr_width-1:0] gpioAddr_i;
  logic [nr_gpios-1:0]        gpio_i;
  logic                       rd_rdy_i;
  logic                       rd_vld_o;
  logic [gpio_addr_width-1:0] rd_addr_o;
  logic [nr_gpios-1:0]        rd_data_o;

  modport master (
    output cs_i, gpioAddr_i, gpio_i, rd_rdy_i,
    input  rd_vld_o, rd_addr_o, rd_data_o
  );

  modport slave (
    input  cs_i, gpioAddr_i, gpio_i, rd_rdy_i,
    output rd_vld_o, rd_addr_o, rd_data_o
  );

endinterface

// File: rtl/as_gpio_capture_sync_fifo.sv
// Single-clock capture FIFO with sticky overflow; a write into a full FIFO is accepted only if the head pops that cycle.
module as_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = !empty && rd_rdy;
  assign push    = wr_en && (!full || pop);
  assign rd_vld  = !empty;
  // Mask the head so stale storage never shows after reset or drain.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_en && full && !pop) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/as_gpio_capture.sv
// GPIO capture: logs every core GPIO write into a FIFO and tracks the test verdict.
// Optional watchdog enabled by defining AS_GPIO_CAPTURE_TIMEOUT_EN.
module as_gpio_capture
  import as_pack::*;
#(
  parameter int DEPTH          = 8,
  parameter int RESULT_ADDR    = DEFAULT_RESULT_ADDR,
  parameter int PASS_VALUE     = DEFAULT_PASS_VALUE,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  as_gpio_capture_if.slave         bus,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o
);

  localparam int EW = gpio_addr_width + nr_gpios;

  as_state_t       state;
  logic            verdict_wr;
  logic            pass_data;
  logic            tmo_hit;
  logic [EW-1:0]   head;

  as_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (bus.cs_i),
    .wr_data ({bus.gpioAddr_i, bus.gpio_i}),
    .rd_rdy  (bus.rd_rdy_i),
    .rd_vld  (bus.rd_vld_o),
    .rd_data (head),
    .full    (full_o),
    .empty   (empty_o),
    .ovf     (ovf_o),
    .count   (count_o)
  );

  assign bus.rd_addr_o = head[EW-1:nr_gpios];
  assign bus.rd_data_o = head[nr_gpios-1:0];

  // Verdict decoding looks only at the write strobe, never at FIFO fullness.
  assign verdict_wr = bus.cs_i && (bus.gpioAddr_i == gpio_addr_width'(RESULT_ADDR));
  assign pass_data  = (bus.gpio_i == nr_gpios'(PASS_VALUE));

`ifdef AS_GPIO_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == RUN) && !bus.cs_i && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else if (bus.cs_i) begin
      tmo_cnt <= '0;
    end else if (tmo_hit) begin
      timeout_o <= 1'b1;
    end else if (state == RUN) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // PASS and FAIL are terminal; only reset returns to IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      done_o <= 1'b0;
      pass_o <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (verdict_wr) begin
            state  <= pass_data ? PASS : FAIL;
            done_o <= 1'b1;
            pass_o <= pass_data;
          end else if (tmo_hit) begin
            state  <= FAIL;
            done_o <= 1'b1;
          end else if (bus.cs_i) begin
            state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_as_gpio_capture.sv
// Directed self-checking bench for as_gpio_capture (DEPTH=8, RESULT_ADDR=4, PASS_VALUE=42).
module tb_as_gpio_capture;
  import as_pack::*;

`ifdef AS_GPIO_CAPTURE_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 100000;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       full_o, empty_o, ovf_o, done_o, pass_o, timeout_o;
  logic [3:0] count_o;
  int         checkCount = 0;
  int         failCount  = 0;

  as_gpio_capture_if bus ();

  as_gpio_capture #(
    .DEPTH          (8),
    .RESULT_ADDR    (4),
    .PASS_VALUE     (42),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .full_o    (full_o),
    .empty_o   (empty_o),
    .ovf_o     (ovf_o),
    .count_o   (count_o),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .timeout_o (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int addr, input int data);
    bus.cs_i       = 1'b1;
    bus.gpioAddr_i = gpio_addr_width'(addr);
    bus.gpio_i     = nr_gpios'(data);
    @(posedge clk_i);
    #1;
    bus.cs_i = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, count_o, 0);
    checkOutput({tag, "_empty"}, empty_o, 1);
    checkOutput({tag, "_full"}, full_o, 0);
    checkOutput({tag, "_ovf"}, ovf_o, 0);
    checkOutput({tag, "_vld"}, bus.rd_vld_o, 0);
    checkOutput({tag, "_addr"}, bus.rd_addr_o, 0);
    checkOutput({tag, "_data"}, bus.rd_data_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_pass"}, pass_o, 0);
    checkOutput({tag, "_tmo"}, timeout_o, 0);
  endtask

  task automatic doReset();
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  // Checks head entry then pops it; rd_rdy_i must already be high.
  task automatic expectHead(input string tag, input int addr, input int data);
    checkOutput({tag, "_vld"}, bus.rd_vld_o, 1);
    checkOutput({tag, "_addr"}, bus.rd_addr_o, 64'(addr));
    checkOutput({tag, "_data"}, bus.rd_data_o, 64'(data));
    @(posedge clk_i);
    #1;
  endtask

  int addrList [4] = '{0, 1, 2, 4};
  int dataList [4] = '{10, 11, 12, 7};
  int hitAt;

  initial begin
    bus.cs_i = 1'b0; bus.gpioAddr_i = '0; bus.gpio_i = '0; bus.rd_rdy_i = 1'b0;

    #2 rst_i = 1'b0;
    #1 checkResetState("por");
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Immediate pass verdict; later writes still enter the FIFO.
    applyStimulus(4, 42);
    checkOutput("pass_done", done_o, 1);
    checkOutput("pass_pass", pass_o, 1);
    checkOutput("pass_count", count_o, 1);
    checkOutput("pass_rdata", bus.rd_data_o, 42);
    checkOutput("pass_raddr", bus.rd_addr_o, 4);
    applyStimulus(4, 7);
    checkOutput("pass_terminal", pass_o, 1);
    checkOutput("pass_count2", count_o, 2);

    // RUN then FAIL, drain in order.
    doReset();
    applyStimulus(0, 10);
    applyStimulus(1, 11);
    applyStimulus(2, 12);
    checkOutput("run_done", done_o, 0);
    applyStimulus(4, 7);
    checkOutput("fail_done", done_o, 1);
    checkOutput("fail_pass", pass_o, 0);
    checkOutput("fail_count", count_o, 4);
    bus.rd_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) expectHead($sformatf("drain%0d", i), addrList[i], dataList[i]);
    checkOutput("drain_empty", empty_o, 1);
    bus.rd_rdy_i = 1'b0;

    // Overflow: ninth write dropped, then simultaneous push/pop while full.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(16 + i, 100 + i);
      if (i == 7) begin
        checkOutput("full8_full", full_o, 1);
        checkOutput("full8_ovf", ovf_o, 0);
      end
    end
    checkOutput("ovf_full", full_o, 1);
    checkOutput("ovf_ovf", ovf_o, 1);
    checkOutput("ovf_count", count_o, 8);
    checkOutput("ovf_head", bus.rd_data_o, 100);
    bus.rd_rdy_i = 1'b1;
    applyStimulus(8'h30, 32'h77);
    bus.rd_rdy_i = 1'b0;
    checkOutput("pp_count", count_o, 8);
    checkOutput("pp_ovf", ovf_o, 1);
    bus.rd_rdy_i = 1'b1;
    for (int j = 0; j < 8; j++)
      expectHead($sformatf("ovfdrain%0d", j), (j < 7) ? 17 + j : 8'h30, (j < 7) ? 101 + j : 32'h77);
    checkOutput("ovfdrain_count", count_o, 0);

    // Streaming 20 writes across pointer wrap with consumer always ready.
    doReset();
    bus.rd_rdy_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32 + i, i * 3 + 1);
      checkOutput($sformatf("stream%0d_data", i), bus.rd_data_o, 64'(i * 3 + 1));
      checkOutput($sformatf("stream%0d_addr", i), bus.rd_addr_o, 64'(32 + i));
      checkOutput($sformatf("stream%0d_count", i), count_o, 1);
    end
    @(posedge clk_i);
    #1;
    checkOutput("stream_empty", empty_o, 1);
    checkOutput("stream_ovf", ovf_o, 0);
    bus.rd_rdy_i = 1'b0;

    // Asynchronous reset mid-cycle with five entries in RUN.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(50 + i, 200 + i);
    checkOutput("mid_count", count_o, 5);
    #3 rst_i = 1'b0;
    #1 checkResetState("mid");
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    applyStimulus(4, 42);
    checkOutput("mid_after_pass", pass_o, 1);
    checkOutput("mid_after_count", count_o, 1);

    // Watchdog.
    doReset();
    applyStimulus(1, 1);
    hitAt = -1;
`ifdef AS_GPIO_CAPTURE_TIMEOUT_EN
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk_i);
      #1;
      if (timeout_o === 1'b1) begin
        hitAt = k;
        break;
      end
    end
    checkOutput("tmo_cycle", 64'(hitAt), 50);
    checkOutput("tmo_flag", timeout_o, 1);
    checkOutput("tmo_done", done_o, 1);
    checkOutput("tmo_pass", pass_o, 0);
`else
    repeat (200) @(posedge clk_i);
    #1;
    checkOutput("notmo_flag", timeout_o, 0);
    checkOutput("notmo_done", done_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/as_gpio_capture.md
AS_GPIO_CAPTURE -- requirements
Module: as_gpio_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning capture FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter RESULT_ADDR, default 4, meaning GPIO address that carries the test verdict.
REQ-003 SHALL have parameter PASS_VALUE, default 42, meaning verdict data that signals pass.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning watchdog limit (used only under REQ-027).
REQ-005 SHALL have port clk_i  in  1  system clock; all state on rising edge.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cs_i  in  1  core GPIO write strobe, one write per cycle high.
REQ-008 SHALL have port gpioAddr_i  in  gpio_addr_width  GPIO write address.
REQ-009 SHALL have port gpio_i  in  nr_gpios  GPIO write data.
REQ-010 SHALL have port rd_rdy_i  in  1  consumer ready.
REQ-011 SHALL have ports rd_vld_o (out, 1, head entry valid), rd_addr_o (out, gpio_addr_width, head address) and rd_data_o (out, nr_gpios, head data).
REQ-012 SHALL have ports full_o, empty_o, ovf_o (out, 1 each): FIFO full, FIFO empty, sticky overflow.
REQ-013 SHALL have port count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have ports done_o, pass_o, timeout_o (out, 1 each): verdict reached, verdict is pass, watchdog expired.

Function
REQ-015 SHALL push {gpioAddr_i, gpio_i} on every rising edge with cs_i=1 and FIFO not full; entry visible on rd_* after that edge (1-cycle latency).
REQ-016 SHALL pop head on rising edge with rd_vld_o=1 and rd_rdy_i=1; rd_* SHALL hold stable while rd_vld_o=1 and rd_rdy_i=0.
REQ-017 Full with push only: write dropped, ovf_o set and held until reset; count_o unchanged.
REQ-018 Full with simultaneous push and pop: both performed, no overflow, count_o stays DEPTH.
REQ-019 Empty with cs_i=1: no pop that cycle (rd_vld_o=0); count_o becomes 1.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; count_o = pushes minus pops.
REQ-021 Status FSM states IDLE, RUN, PASS, FAIL; IDLE->RUN on first accepted or dropped write to any address other than RESULT_ADDR.
REQ-022 IDLE/RUN -> PASS on write to RESULT_ADDR with data==PASS_VALUE (zero-extended); -> FAIL on any other data at RESULT_ADDR.
REQ-023 PASS and FAIL SHALL be terminal until reset; further writes still enter the FIFO.
REQ-024 done_o=1 in PASS/FAIL; pass_o=1 only in PASS; both registered, asserted the cycle after the verdict write.
REQ-025 Verdict evaluation SHALL be independent of FIFO fullness.

Reset
REQ-026 rst_i=0 SHALL immediately clear pointers, count_o=0, empty_o=1, full_o=0, ovf_o=0, rd_vld_o=0, rd_addr_o=0, rd_data_o=0, FSM=IDLE, done_o=0, pass_o=0, timeout_o=0, mid-operation included; FIFO contents discarded.

Configuration
REQ-027 With AS_GPIO_CAPTURE_TIMEOUT_EN defined: a counter increments each cycle in RUN, clears on cs_i=1; on reaching TIMEOUT_CYCLES FSM -> FAIL and timeout_o=1 (sticky); without it no counter is built and timeout_o ties to 0.

Structure
REQ-028 as_pack SHALL hold the status FSM enum typedef and default constants for RESULT_ADDR and PASS_VALUE; nr_gpios and gpio_addr_width come from as_pack.
REQ-029 FIFO storage/pointers SHALL be one sub-module as_sync_fifo; FSM and watchdog stay in as_gpio_capture.

Verification
REQ-030 Write addr 4 data 42 after reset -> next cycle done_o=1, pass_o=1, count_o=1, rd_data_o=42.
REQ-031 Writes addr 0..2 then addr 4 data 7 -> FSM RUN then FAIL, done_o=1, pass_o=0; FIFO drains 0,1,2,4 in order.
REQ-032 rd_rdy_i=0, 9 writes with DEPTH=8 -> full_o=1, ovf_o=1, count_o=8, 9th entry absent; then push+pop same cycle keeps count_o=8, ovf_o unchanged.
REQ-033 rd_rdy_i=1, 20 back-to-back writes -> all 20 read in order across pointer wrap, ovf_o=0.
REQ-034 rst_i low for 1 cycle with count_o=5 in RUN -> all outputs at reset values same cycle, FSM IDLE.
REQ-035 With AS_GPIO_CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=50, one write then silence -> timeout_o=1, done_o=1, pass_o=0 at cycle 50; without macro timeout_o stays 0.
